// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC-style RAM responder: op3 codes,
// FSM state encoding, access size codes and opcode decode helpers.
package sparc_mem_pkg;

   localparam logic [5:0] OP_LD   = 6'b000000;
   localparam logic [5:0] OP_LDUB = 6'b000001;
   localparam logic [5:0] OP_LDUH = 6'b000010;
   localparam logic [5:0] OP_ST   = 6'b000100;
   localparam logic [5:0] OP_STB  = 6'b000101;
   localparam logic [5:0] OP_STH  = 6'b000110;
   localparam logic [5:0] OP_LDSB = 6'b001001;
   localparam logic [5:0] OP_LDSH = 6'b001010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } size_t;

   // Unsupported opcodes map to SZ_NONE so they never touch the array.
   function automatic size_t op_to_size(input logic [5:0] op);
      case (op)
         OP_LDUB, OP_LDSB, OP_STB: return SZ_BYTE;
         OP_LDUH, OP_LDSH, OP_STH: return SZ_HALF;
         OP_LD, OP_ST:             return SZ_WORD;
         default:                  return SZ_NONE;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [5:0] op);
      return (op == OP_ST) || (op == OP_STB) || (op == OP_STH);
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational big-endian lane steering for the RAM responder.
// Store side turns opcode/offset/data into per-byte enables and replicated
// lane data; load side picks and extends the addressed bytes of a word.
// Byte enable bit k and lane k refer to the byte at word offset k,
// which sits in bits [31-8k -: 8] of the word (big-endian).
module mem_byte_lane
   import sparc_mem_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] read_word,
   output logic [3:0]  byte_we,
   output logic [31:0] lane_data,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Store steering: enables for the addressed bytes, data copied onto every lane.
   always_comb begin
      byte_we   = 4'b0000;
      lane_data = store_data;
      case (op)
         OP_ST: begin
            byte_we   = 4'b1111;
            lane_data = store_data;
         end
         OP_STB: begin
            byte_we   = 4'b0001 << addr_lo;
            lane_data = {4{store_data[7:0]}};
         end
         OP_STH: begin
            byte_we   = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{store_data[15:0]}};
         end
         default: begin
            byte_we   = 4'b0000;
            lane_data = store_data;
         end
      endcase
   end

   // Load extraction: pick the addressed byte/half and extend it per opcode.
   always_comb begin
      sel_byte  = read_word[31:24];
      sel_half  = addr_lo[1] ? read_word[15:0] : read_word[31:16];
      load_data = 32'd0;
      case (addr_lo)
         2'd0: sel_byte = read_word[31:24];
         2'd1: sel_byte = read_word[23:16];
         2'd2: sel_byte = read_word[15:8];
         default: sel_byte = read_word[7:0];
      endcase
      case (op)
         OP_LD:   load_data = read_word;
         OP_LDUB: load_data = {24'd0, sel_byte};
         OP_LDSB: load_data = {{24{sel_byte[7]}}, sel_byte};
         OP_LDUH: load_data = {16'd0, sel_half};
         OP_LDSH: load_data = {{16{sel_half[15]}}, sel_half};
         default: load_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_mfc_responder.sv
// Responder end of the RAM_enable/MFC four-phase handshake. Latches the
// request, waits WAIT_STATES cycles, performs the access on a big-endian
// byte array, raises MFC and holds it until RAM_enable drops.
// Optional feature macro: MEM_ALIGN_CHECK_EN (flag misaligned accesses
// instead of forcing them to alignment).
module mem_mfc_responder
   import sparc_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 2
)(
   input  logic        Clk,
   input  logic        RESET,
   input  logic        RAM_enable,
   input  logic [5:0]  RAM_OpCode,
   input  logic [31:0] RAM_addr,
   input  logic [31:0] RAM_data_in,
   output logic [31:0] RAM_data_out,
   output logic        MFC,
   output logic        align_err
);

   state_t state, state_next;

   logic [5:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;
   logic [3:0]            count;
   logic [31:0]           out_q;
   logic                  mfc_q;

   logic latch, dec, complete, release_req;

   size_t                 size;
   logic [1:0]            lane_addr;
   logic                  misaligned;
   logic [3:0]            byte_we;
   logic [31:0]           lane_data;
   logic [31:0]           read_word;
   logic [31:0]           load_data;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic                  unused_addr_bits;

   logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

   assign unused_addr_bits = ^RAM_addr[31:ADDR_WIDTH];

   assign size      = op_to_size(op_q);
   assign word_idx  = addr_q[ADDR_WIDTH-1:2];
   assign read_word = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                       mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

   // Offset within the word after forcing halves/words onto their natural boundary.
   always_comb begin
      lane_addr = addr_q[1:0];
      case (size)
         SZ_HALF: lane_addr = {addr_q[1], 1'b0};
         SZ_WORD: lane_addr = 2'b00;
         default: lane_addr = addr_q[1:0];
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   // Misaligned half/word accesses complete without touching the array.
   always_comb begin
      misaligned = ((size == SZ_HALF) && addr_q[0]) ||
                   ((size == SZ_WORD) && (addr_q[1:0] != 2'b00));
   end
`else
   assign misaligned = 1'b0;
`endif

   mem_byte_lane u_lane (
      .op         (op_q),
      .addr_lo    (lane_addr),
      .store_data (data_q),
      .read_word  (read_word),
      .byte_we    (byte_we),
      .lane_data  (lane_data),
      .load_data  (load_data)
   );

   // State register; reset wins from any state.
   always_ff @(posedge Clk) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state and handshake control; a dropped request in BUSY aborts.
   always_comb begin
      state_next  = state;
      latch       = 1'b0;
      dec         = 1'b0;
      complete    = 1'b0;
      release_req = 1'b0;
      case (state)
         S_IDLE: begin
            if (RAM_enable) begin
               latch      = 1'b1;
               state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!RAM_enable) begin
               state_next = S_IDLE;
            end else if (count != 4'd0) begin
               dec = 1'b1;
            end else begin
               complete   = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (!RAM_enable) begin
               release_req = 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operand latches, wait counter, load result and MFC.
   always_ff @(posedge Clk) begin
      if (RESET) begin
         op_q   <= 6'd0;
         addr_q <= '0;
         data_q <= 32'd0;
         count  <= 4'd0;
         out_q  <= 32'd0;
         mfc_q  <= 1'b0;
      end else begin
         if (latch) begin
            op_q   <= RAM_OpCode;
            addr_q <= RAM_addr[ADDR_WIDTH-1:0];
            data_q <= RAM_data_in;
            count  <= 4'(WAIT_STATES);
         end else if (dec) begin
            count <= count - 4'd1;
         end
         if (complete) begin
            mfc_q <= 1'b1;
            if (misaligned)              out_q <= 32'd0;
            else if (!op_is_store(op_q)) out_q <= load_data;
         end else if (release_req) begin
            mfc_q <= 1'b0;
         end
      end
   end

   // Byte array write; never cleared, and a store cut off by reset is dropped.
   always_ff @(posedge Clk) begin
      if (!RESET && complete && !misaligned) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_we[k]) mem[{word_idx, 2'(k)}] <= lane_data[8*(3-k) +: 8];
         end
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic align_q;

   // Alignment flag, valid for the whole time MFC is high.
   always_ff @(posedge Clk) begin
      if (RESET)            align_q <= 1'b0;
      else if (complete)    align_q <= misaligned;
      else if (release_req) align_q <= 1'b0;
   end

   assign align_err = align_q;
`else
   assign align_err = 1'b0;
`endif

   assign RAM_data_out = out_q;
   assign MFC          = mfc_q;

endmodule

// File: tb/tb_mem_mfc_responder.sv
// Directed testbench for mem_mfc_responder (ADDR_WIDTH=9, WAIT_STATES=2).
// Expected values depend on MEM_ALIGN_CHECK_EN where alignment matters.
module tb_mem_mfc_responder;
   import sparc_mem_pkg::*;

   logic        Clk;
   logic        RESET;
   logic        RAM_enable;
   logic [5:0]  RAM_OpCode;
   logic [31:0] RAM_addr;
   logic [31:0] RAM_data_in;
   logic [31:0] RAM_data_out;
   logic        MFC;
   logic        align_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] obs_data;
   logic        obs_align;
   logic        obs_seen;
   logic        mfc_any;

   mem_mfc_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut (
      .Clk          (Clk),
      .RESET        (RESET),
      .RAM_enable   (RAM_enable),
      .RAM_OpCode   (RAM_OpCode),
      .RAM_addr     (RAM_addr),
      .RAM_data_in  (RAM_data_in),
      .RAM_data_out (RAM_data_out),
      .MFC          (MFC),
      .align_err    (align_err)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // One full four-phase transaction; returns the values seen while MFC was high.
   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] d,
                                output logic a, output logic seen);
      RAM_OpCode  = op;
      RAM_addr    = addr;
      RAM_data_in = data;
      RAM_enable  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge Clk); #1;
         if (MFC) seen = 1'b1;
      end
      d = RAM_data_out;
      a = align_err;
      RAM_enable = 1'b0;
      @(posedge Clk); #1;
   endtask

   initial begin
      RESET       = 1'b1;
      RAM_enable  = 1'b0;
      RAM_OpCode  = OP_LD;
      RAM_addr    = 32'd0;
      RAM_data_in = 32'd0;
      repeat (2) @(posedge Clk);
      #1;
      RESET = 1'b0;

      checkOutput("reset_mfc", 32'(MFC), 32'd0);
      checkOutput("reset_data", RAM_data_out, 32'd0);
      checkOutput("reset_align", 32'(align_err), 32'd0);

      applyStimulus(OP_ST, 32'h10, 32'h12345678, obs_data, obs_align, obs_seen);
      checkOutput("st10_mfc", 32'(obs_seen), 32'd1);
      checkOutput("st10_release", 32'(MFC), 32'd0);

      applyStimulus(OP_LD, 32'h10, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ld10_mfc", 32'(obs_seen), 32'd1);
      checkOutput("ld10", obs_data, 32'h12345678);
      checkOutput("ld10_align", 32'(obs_align), 32'd0);
      applyStimulus(OP_LDUB, 32'h11, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldub11", obs_data, 32'h00000034);
      applyStimulus(OP_LDSH, 32'h10, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldsh10", obs_data, 32'h00001234);
      applyStimulus(OP_LDUH, 32'h12, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("lduh12", obs_data, 32'h00005678);
      applyStimulus(OP_LDSB, 32'h10, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldsb10", obs_data, 32'h00000012);

      applyStimulus(OP_ST, 32'h20, 32'h01020304, obs_data, obs_align, obs_seen);
      applyStimulus(OP_STB, 32'h21, 32'hFFFFFF85, obs_data, obs_align, obs_seen);
      applyStimulus(OP_LDSB, 32'h21, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldsb21", obs_data, 32'hFFFFFF85);
      applyStimulus(OP_LDUB, 32'h21, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldub21", obs_data, 32'h00000085);
      applyStimulus(OP_LD, 32'h20, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ld20_after_stb", obs_data, 32'h01850304);

      applyStimulus(OP_STH, 32'h22, 32'h0000BEEF, obs_data, obs_align, obs_seen);
      applyStimulus(OP_LD, 32'h20, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ld20_after_sth", obs_data, 32'h0185BEEF);
      applyStimulus(OP_LDSH, 32'h22, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldsh22", obs_data, 32'hFFFFBEEF);
      applyStimulus(OP_STB, 32'h30, 32'h00000007, obs_data, obs_align, obs_seen);
      checkOutput("store_keeps_data", obs_data, 32'hFFFFBEEF);

      // Latency: request sampled at edge N, MFC visible after edge N+3.
      RAM_OpCode = OP_LD;
      RAM_addr   = 32'h10;
      RAM_enable = 1'b1;
      @(posedge Clk); #1;
      checkOutput("lat_n0", 32'(MFC), 32'd0);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      checkOutput("lat_n2", 32'(MFC), 32'd0);
      @(posedge Clk); #1;
      checkOutput("lat_n3", 32'(MFC), 32'd1);
      checkOutput("lat_data", RAM_data_out, 32'h12345678);
      RAM_addr = 32'h20;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("hold_mfc", 32'(MFC), 32'd1);
      checkOutput("hold_data", RAM_data_out, 32'h12345678);
      RAM_enable = 1'b0;
      @(posedge Clk); #1;
      checkOutput("drop_mfc", 32'(MFC), 32'd0);

      // Abort: request withdrawn one cycle into BUSY.
      applyStimulus(OP_ST, 32'h40, 32'h11111111, obs_data, obs_align, obs_seen);
      RAM_OpCode  = OP_ST;
      RAM_addr    = 32'h40;
      RAM_data_in = 32'hAAAAAAAA;
      RAM_enable  = 1'b1;
      @(posedge Clk); #1;
      RAM_enable = 1'b0;
      mfc_any = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk); #1;
         mfc_any = mfc_any | MFC;
      end
      checkOutput("abort_mfc", 32'(mfc_any), 32'd0);
      applyStimulus(OP_LD, 32'h40, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("abort_nowrite", obs_data, 32'h11111111);

      // Alignment behaviour depends on the build.
      applyStimulus(OP_LD, 32'h13, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ld13_mfc", 32'(obs_seen), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("ld13_data", obs_data, 32'h00000000);
      checkOutput("ld13_align", 32'(obs_align), 32'd1);
`else
      checkOutput("ld13_data", obs_data, 32'h12345678);
      checkOutput("ld13_align", 32'(obs_align), 32'd0);
`endif
      checkOutput("align_cleared", 32'(align_err), 32'd0);
      applyStimulus(OP_STH, 32'h23, 32'h0000CAFE, obs_data, obs_align, obs_seen);
      applyStimulus(OP_LD, 32'h20, 32'h0, obs_data, obs_align, obs_seen);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("sth23_effect", obs_data, 32'h0185BEEF);
`else
      checkOutput("sth23_effect", obs_data, 32'h0185CAFE);
`endif

      // Address wrap modulo 512 bytes.
      applyStimulus(OP_LD, 32'h210, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("wrap_210", obs_data, 32'h12345678);
      applyStimulus(OP_LD, 32'hFFFF0010, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("wrap_high", obs_data, 32'h12345678);

      // Unsupported op3 (LDD) still completes, with a zero result.
      applyStimulus(6'b000011, 32'h10, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("ldd_mfc", 32'(obs_seen), 32'd1);
      checkOutput("ldd_data", obs_data, 32'h00000000);

      // Reset held two cycles mid-BUSY drops the store and clears outputs.
      applyStimulus(OP_ST, 32'h50, 32'h55667788, obs_data, obs_align, obs_seen);
      applyStimulus(OP_LD, 32'h10, 32'h0, obs_data, obs_align, obs_seen);
      RAM_OpCode  = OP_ST;
      RAM_addr    = 32'h50;
      RAM_data_in = 32'hDEADBEEF;
      RAM_enable  = 1'b1;
      @(posedge Clk); #1;
      RESET      = 1'b1;
      RAM_enable = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("rst_busy_mfc", 32'(MFC), 32'd0);
      checkOutput("rst_busy_data", RAM_data_out, 32'd0);
      RESET = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("rst_after_mfc", 32'(MFC), 32'd0);
      applyStimulus(OP_LD, 32'h50, 32'h0, obs_data, obs_align, obs_seen);
      checkOutput("rst_nowrite", obs_data, 32'h55667788);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
